// File: rtl/adc_spi_pkg.sv
// Shared types and sizing helpers for the serial-ADC capture front end.
package adc_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StShift,
        StDone,
        StGap
    } state_e;

    localparam int unsigned STATE_W = 3;

    function automatic int unsigned frame_bits(input int unsigned data_w,
                                               input int unsigned num_ch,
                                               input int unsigned gap_bits);
        return num_ch * (gap_bits + data_w) + gap_bits;
    endfunction

    // Width of a counter that must hold 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/adc_spi_capture_if.sv
// Serial ADC pins plus the captured-frame valid/ready stream.
interface adc_spi_capture_if #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned NUM_CH = 2
) ();

    logic                     start;
    logic                     continuous;
    logic                     miso;
    logic                     sck;
    logic                     ad_conv;
    logic                     busy;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic                     sample_valid;
    logic                     sample_ready;
    logic                     overrun;

    modport master (
        input  start, continuous, miso, sample_ready,
        output sck, ad_conv, busy, sample_data, sample_valid, overrun
    );

    modport slave (
        output start, continuous, miso, sample_ready,
        input  sck, ad_conv, busy, sample_data, sample_valid, overrun
    );

endinterface

// File: rtl/adc_sck_gen.sv
// SCK divider: tick every CLK_DIV cycles while enabled, sck toggles on ticks while run.
module adc_sck_gen
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clock_in,
    input  logic reset,
    input  logic en,
    input  logic clear,
    input  logic run,
    output logic tick,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall
);

    localparam int unsigned DIV_W = cnt_width(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             sck_q;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else begin
            if (!en || clear || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            if (!en || !run) begin
                sck_q <= 1'b0;
            end else if (tick) begin
                sck_q <= ~sck_q;
            end
        end
    end

    always_comb begin
        tick     = en && !clear && (div_q == DIV_LAST);
        sck      = sck_q;
        sck_rise = tick && run && !sck_q;
        sck_fall = tick && run && sck_q;
    end

endmodule

// File: rtl/adc_spi_capture.sv
// Serial-ADC capture: conversion strobe, SCK framing, per-channel deserialise, frame output.
module adc_spi_capture
    import adc_spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned GAP_BITS  = 2,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned FRAME_GAP = 0
) (
    input logic               clock_in,
    input logic               reset,
    adc_spi_capture_if.master bus
);

    localparam int unsigned FRAME_BITS = frame_bits(DATA_W, NUM_CH, GAP_BITS);
    localparam int unsigned SLOT       = GAP_BITS + DATA_W;
    localparam int unsigned GAP_TICKS  = 2 * FRAME_GAP;
    localparam int unsigned BIT_W      = cnt_width(FRAME_BITS);
    localparam int unsigned SLOT_W     = cnt_width(SLOT - 1);
    localparam int unsigned CH_W       = cnt_width(NUM_CH);
    localparam int unsigned TICK_W     = cnt_width((GAP_TICKS > 2) ? GAP_TICKS : 2);
    localparam logic [TICK_W-1:0] CONV_LAST = TICK_W'(1);
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'((GAP_TICKS == 0) ? 0 : GAP_TICKS - 1);

    state_e state_q, state_d;

    logic                     tick, sck, sck_rise, sck_fall;
    logic                     busy, conv_done, gap_done, frame_end, data_bit;
    logic [TICK_W-1:0]        tick_cnt_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic [SLOT_W-1:0]        slot_q;
    logic [CH_W-1:0]          ch_q;
    logic [DATA_W-1:0]        chan_q [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] frame_w;
    logic [NUM_CH*DATA_W-1:0] data_q;
    logic                     valid_q, overrun_q;

    adc_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clock_in (clock_in),
        .reset    (reset),
        .en       (busy),
        .clear    (state_q == StDone),
        .run      (state_q == StShift),
        .tick     (tick),
        .sck      (sck),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    always_comb begin
        busy      = (state_q != StIdle);
        conv_done = (state_q == StConv) && tick && (tick_cnt_q == CONV_LAST);
        gap_done  = (state_q == StGap) && tick && (tick_cnt_q == GAP_LAST);
        frame_end = (state_q == StShift) && sck_fall && (bit_cnt_q == BIT_W'(FRAME_BITS));
        data_bit  = (slot_q >= SLOT_W'(GAP_BITS)) && (ch_q < CH_W'(NUM_CH));
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start || bus.continuous) state_d = StConv;
            StConv:  if (conv_done) state_d = StShift;
            StShift: if (frame_end) state_d = StDone;
            StDone: begin
                if (!bus.continuous) begin
                    state_d = StIdle;
                end else if (FRAME_GAP == 0) begin
                    state_d = StConv;
                end else begin
                    state_d = StGap;
                end
            end
            StGap:   if (gap_done) state_d = StConv;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.sck          = sck;
        bus.ad_conv      = (state_q == StConv);
        bus.busy         = busy;
        bus.sample_data  = data_q;
        bus.sample_valid = valid_q;
        bus.overrun      = overrun_q;
    end

    // Bit position is tracked as (channel, slot) so gap/data decode needs no divide.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            slot_q     <= '0;
            ch_q       <= '0;
            for (int c = 0; c < NUM_CH; c++) chan_q[c] <= '0;
        end else begin
            if (conv_done || gap_done || !(state_q inside {StConv, StGap})) begin
                tick_cnt_q <= '0;
            end else if (tick) begin
                tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
            if (state_q != StShift) begin
                bit_cnt_q <= '0;
                slot_q    <= '0;
                ch_q      <= '0;
            end else if (sck_rise) begin
                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                if (slot_q == SLOT_W'(SLOT - 1)) begin
                    slot_q <= '0;
                    ch_q   <= ch_q + CH_W'(1);
                end else begin
                    slot_q <= slot_q + SLOT_W'(1);
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (data_bit && (ch_q == CH_W'(c))) begin
                        chan_q[c] <= {chan_q[c][DATA_W-2:0], bus.miso};
                    end
                end
            end
        end
    end

    always_comb begin
        frame_w = '0;
        for (int c = 0; c < NUM_CH; c++) frame_w[c*DATA_W +: DATA_W] = chan_q[c];
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (state_q == StDone) begin
                data_q    <= frame_w;
                valid_q   <= 1'b1;
                overrun_q <= valid_q && !bus.sample_ready;
            end else if (valid_q && bus.sample_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
